// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types and ShiftRows geometry helpers
package aes_pkg;
  typedef logic [7:0] aes_byte_t;
  typedef logic [127:0] aes_state_t;
  function automatic bit nb_legal(int nb);
    return nb == 4 || nb == 6 || nb == 8;
  endfunction
  function automatic int shift_ofs(int nb, int row);
    return (nb == 8 && row > 1) ? row + 1 : row;
  endfunction
  function automatic int byte_idx(int r, int c);
    return r + 4 * c;
  endfunction
endpackage

// File: rtl/shiftrows_pipe_if.sv
// shiftrows_pipe_if: valid/ready block stream into and out of the ShiftRows pipeline
interface shiftrows_pipe_if #(parameter int NB = 4, parameter int DEPTH = 1);
  logic in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [32*NB-1:0] in_data, out_data;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (output in_valid, in_inv, in_data, out_ready, input in_ready, out_valid, out_data, occupancy);
  modport slave (input in_valid, in_inv, in_data, out_ready, output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/shiftrows_perm.sv
// shiftrows_perm: combinational Rijndael ShiftRows / InvShiftRows byte permutation
module shiftrows_perm import aes_pkg::*; #(parameter int NB = 4) (
  input  logic            inv_i,
  input  logic [32*NB-1:0] data_i,
  output logic [32*NB-1:0] data_o
);
  localparam int W = 32 * NB;
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < NB; c++) begin : g_c
      localparam int S = shift_ofs(NB, r);
      localparam int DST = W - 8 - 8 * byte_idx(r, c);
      localparam int FWD = W - 8 - 8 * byte_idx(r, (c + S) % NB);
      localparam int INV = W - 8 - 8 * byte_idx(r, (c + NB - S) % NB);
      assign data_o[DST +: 8] = inv_i ? data_i[INV +: 8] : data_i[FWD +: 8];
    end
  end
endmodule

// File: rtl/shiftrows_pipe.sv
// shiftrows_pipe: permutation in front of a DEPTH-stage elastic register chain
module shiftrows_pipe import aes_pkg::*; #(parameter int NB = 4, parameter int DEPTH = 1) (
  input logic clk,
  input logic rst_n,
  shiftrows_pipe_if.slave bus
);
  localparam int W = 32 * NB;
  localparam int OW = $clog2(DEPTH + 1);
  if (!nb_legal(NB) || DEPTH < 1 || DEPTH > 4) begin : g_bad
    $error("shiftrows_pipe: illegal NB=%0d or DEPTH=%0d", NB, DEPTH);
  end
  logic [W-1:0] perm;
  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] data_d [DEPTH];
  logic [W-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, up_v, rdy;
  logic [OW-1:0] occ;
  shiftrows_perm #(.NB(NB)) u_perm (.inv_i(bus.in_inv), .data_i(bus.in_data), .data_o(perm));
  // a stage may load when downstream is ready or any later stage has a hole
  always_comb begin
    up_v[0] = bus.in_valid;
    up_d[0] = perm;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = valid_q[i-1];
      up_d[i] = data_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = bus.out_ready || ((~valid_q) >> i) != '0;
      valid_d[i] = rdy[i] ? up_v[i] : valid_q[i];
      data_d[i] = (rdy[i] && up_v[i]) ? up_d[i] : data_q[i];
    end
  end
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(valid_q[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign bus.in_ready = rdy[0];
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data = data_q[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb_shiftrows_pipe: directed vectors plus stall/reset sequences across several NB/DEPTH configurations
module tb_shiftrows_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  shiftrows_pipe_if #(.NB(4), .DEPTH(1)) b4 ();
  shiftrows_pipe_if #(.NB(8), .DEPTH(1)) b8 ();
  shiftrows_pipe_if #(.NB(6), .DEPTH(1)) b6 ();
  shiftrows_pipe_if #(.NB(4), .DEPTH(3)) b3 ();
  shiftrows_pipe_if #(.NB(4), .DEPTH(2)) b2 ();
  shiftrows_pipe #(.NB(4), .DEPTH(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  shiftrows_pipe #(.NB(8), .DEPTH(1)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  shiftrows_pipe #(.NB(6), .DEPTH(1)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));
  shiftrows_pipe #(.NB(4), .DEPTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  shiftrows_pipe #(.NB(4), .DEPTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  typedef struct {
    string name;
    logic inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [4];
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] model(int nb, bit inv, logic [255:0] d);
    logic [255:0] o;
    int ofs8 [4];
    int w, s, src;
    ofs8 = '{0, 1, 3, 4};
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        s = (nb == 8) ? ofs8[r] : r;
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        o[w-1-8*(r+4*c) -: 8] = d[w-1-8*(r+4*src) -: 8];
      end
    return o;
  endfunction
  function automatic logic [255:0] ramp(int nb);
    logic [255:0] o;
    o = '0;
    for (int k = 0; k < 4 * nb; k++) o[32*nb-1-8*k -: 8] = 8'(k);
    return o;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [255:0] r8;
    logic [127:0] q[$];
    logic [127:0] held, blk_a, blk_b, blk_c, blk_d;
    logic [7:0] row3 [8];
    int sent, got, cyc;
    bit stall;
    tbl[0] = '{"fips_fwd", 1'b0, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    tbl[1] = '{"fips_inv", 1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
    tbl[2] = '{"ramp_fwd", 1'b0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h00050a0f_04090e03_080d0207_0c01060b};
    tbl[3] = '{"ramp_inv", 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h000d0a07_04010e0b_0805020f_0c090603};
    row3 = '{8'h13, 8'h17, 8'h1b, 8'h1f, 8'h03, 8'h07, 8'h0b, 8'h0f};
    rst_n = 1'b0;
    {b4.in_valid, b8.in_valid, b6.in_valid, b3.in_valid, b2.in_valid} = '0;
    {b4.in_inv, b8.in_inv, b6.in_inv, b3.in_inv, b2.in_inv} = '0;
    b4.in_data = '0; b8.in_data = '0; b6.in_data = '0; b3.in_data = '0; b2.in_data = '0;
    {b4.out_ready, b8.out_ready, b6.out_ready, b3.out_ready, b2.out_ready} = '1;
    #2;
    chk("rst_out_valid", b2.out_valid, 0);
    chk("rst_out_data", b2.out_data, 0);
    chk("rst_occupancy", b2.occupancy, 0);
    chk("rst_in_ready", b2.in_ready, 1);
    chk("rst_d3_occupancy", b3.occupancy, 0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      b4.in_inv = tbl[i].inv;
      b4.in_data = tbl[i].din;
      @(negedge clk);
      b4.in_valid = 1'b0;
      chk({tbl[i].name, "_valid"}, b4.out_valid, 1);
      chk(tbl[i].name, b4.out_data, tbl[i].exp);
    end
    b4.in_data = 128'hffff;
    @(negedge clk);
    chk("idle_no_valid", b4.out_valid, 0);
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_inv = 1'b0;
    b8.in_data = ramp(8);
    @(negedge clk);
    r8 = b8.out_data;
    chk("nb8_fwd_valid", b8.out_valid, 1);
    for (int c = 0; c < 8; c++) chk($sformatf("nb8_row3_c%0d", c), r8[255-8*(3+4*c) -: 8], row3[c]);
    chk("nb8_fwd_model", r8, model(8, 1'b0, ramp(8)));
    b8.in_inv = 1'b1;
    b8.in_data = r8;
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk("nb8_roundtrip", b8.out_data, ramp(8));
    b6.in_valid = 1'b1;
    b6.in_inv = 1'b0;
    b6.in_data = ramp(6);
    @(negedge clk);
    chk("nb6_fwd", b6.out_data, model(6, 1'b0, ramp(6)));
    r8 = b6.out_data;
    b6.in_inv = 1'b1;
    @(negedge clk);
    chk("nb6_inv", b6.out_data, model(6, 1'b1, ramp(6)));
    b6.in_data = r8;
    @(negedge clk);
    b6.in_valid = 1'b0;
    chk("nb6_roundtrip", b6.out_data, ramp(6));
    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    while ((sent < 10 || got < 10) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall_valid", b3.out_valid, 1);
        chk("stall_data", b3.out_data, held);
      end
      chk("d3_occupancy", b3.occupancy, q.size());
      b3.in_valid = sent < 10;
      b3.in_inv = sent[0];
      b3.in_data = {$urandom, $urandom, $urandom, $urandom};
      b3.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (b3.in_valid && b3.in_ready) begin
        q.push_back(model(4, b3.in_inv, b3.in_data));
        sent++;
      end
      if (b3.out_valid && b3.out_ready) begin
        if (q.size() == 0) chk("d3_spurious_output", 1, 0);
        else chk("d3_stream", b3.out_data, q.pop_front());
        got++;
      end
      stall = b3.out_valid && !b3.out_ready;
      held = b3.out_data;
    end
    b3.in_valid = 1'b0;
    chk("d3_received", got, 10);
    chk("d3_leftover", q.size(), 0);
    blk_a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    blk_b = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    blk_c = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    blk_d = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    @(negedge clk);
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1;
    b2.in_inv = 1'b0;
    b2.in_data = blk_a;
    @(negedge clk);
    b2.in_inv = 1'b1;
    b2.in_data = blk_b;
    @(negedge clk);
    b2.in_valid = 1'b0;
    chk("full_occupancy", b2.occupancy, 2);
    chk("full_in_ready", b2.in_ready, 0);
    chk("full_out_valid", b2.out_valid, 1);
    chk("full_out_data", b2.out_data, model(4, 1'b0, blk_a));
    @(negedge clk);
    chk("hold_occupancy", b2.occupancy, 2);
    chk("hold_out_data", b2.out_data, model(4, 1'b0, blk_a));
    b2.in_valid = 1'b1;
    b2.in_inv = 1'b0;
    b2.in_data = blk_c;
    b2.out_ready = 1'b1;
    #1;
    chk("passthru_in_ready", b2.in_ready, 1);
    @(negedge clk);
    chk("shift_occupancy", b2.occupancy, 2);
    chk("shift_out_data", b2.out_data, model(4, 1'b1, blk_b));
    b2.in_valid = 1'b0;
    b2.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", b2.out_valid, 0);
    chk("async_rst_data", b2.out_data, 0);
    chk("async_rst_occupancy", b2.occupancy, 0);
    chk("async_rst_in_ready", b2.in_ready, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", b2.out_valid, 0);
    b2.in_valid = 1'b1;
    b2.in_inv = 1'b1;
    b2.in_data = blk_d;
    b2.out_ready = 1'b1;
    @(negedge clk);
    b2.in_valid = 1'b0;
    chk("post_rst_lat1_valid", b2.out_valid, 0);
    chk("post_rst_lat1_occ", b2.occupancy, 1);
    @(negedge clk);
    chk("post_rst_valid", b2.out_valid, 1);
    chk("post_rst_data", b2.out_data, model(4, 1'b1, blk_d));
    @(negedge clk);
    chk("post_rst_drained", b2.out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
